// File: rtl/fetch_unit_pkg.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit_pkg
// Brief    : Shared types, opcode match constants and FSM encoding for the
//            fetch stage (bundle layout, branch prediction payload).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_unit_pkg;

  localparam int CACHE_LINE_BYTES   = 64;
  localparam int INSTRUCTION_WIDTH  = 4;
  localparam int SUPER_SCALAR_WIDTH = 2;

  // Opcode fields that end a bundle (taken or predicted-taken control flow)
  localparam logic [5:0]  OPC_B     = 6'b000101;      // bits[31:26]
  localparam logic [5:0]  OPC_BL    = 6'b100101;      // bits[31:26]
  localparam logic [10:0] OPC_RET   = 11'b11010110010; // bits[31:21]
  localparam logic [7:0]  OPC_BCOND = 8'b01010100;    // bits[31:24]

  // Fetch FSM encoding
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_WAIT_L1I = 2'd1;
  localparam logic [1:0] ST_DROP     = 2'd2;

  typedef struct packed {
    logic        predict_taken;
    logic [63:0] predict_target;
  } uop_branch;

  typedef struct packed {
    logic [63:0]                               pc;
    logic [SUPER_SCALAR_WIDTH-1:0]             lane_valid;
    logic [SUPER_SCALAR_WIDTH-1:0][31:0]       instr;
    uop_branch [SUPER_SCALAR_WIDTH-1:0]        branch_data;
  } fetch_bundle_t;

  // Unconditional branches and returns always redirect; bcond only when
  // the predictor says taken.
  function automatic logic is_redirect(input logic [31:0] instr, input logic taken);
    return (instr[31:26] == OPC_B) || (instr[31:26] == OPC_BL) ||
           (instr[31:21] == OPC_RET) || ((instr[31:24] == OPC_BCOND) && taken);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit_if
// Brief    : BP / L1I / decode side bus of the fetch stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic                                    bp_pc_valid;
  logic [63:0]                             bp_pred_pc;
  logic                                    bp_l0_valid;
  logic                                    bp_l1i_valid;
  logic [CACHE_LINE_BYTES*8-1:0]           bp_l0_cacheline;
  uop_branch [SUPER_SCALAR_WIDTH-1:0]      bp_branch_data;
  logic                                    l1i_valid;
  logic [CACHE_LINE_BYTES*8-1:0]           l1i_cacheline;
  logic                                    flush_in;
  logic                                    fetch_ready;
  logic                                    decode_ready;
  logic                                    decode_valid;
  logic [63:0]                             decode_pc;
  logic [SUPER_SCALAR_WIDTH-1:0]           decode_lane_valid;
  logic [SUPER_SCALAR_WIDTH-1:0][31:0]     decode_instr;
  uop_branch [SUPER_SCALAR_WIDTH-1:0]      decode_branch_data;

  // Environment side (BP, L1I, decode)
  modport master (
    output bp_pc_valid, bp_pred_pc, bp_l0_valid, bp_l1i_valid, bp_l0_cacheline,
           bp_branch_data, l1i_valid, l1i_cacheline, flush_in, decode_ready,
    input  fetch_ready, decode_valid, decode_pc, decode_lane_valid, decode_instr,
           decode_branch_data
  );

  // Fetch unit side
  modport slave (
    input  bp_pc_valid, bp_pred_pc, bp_l0_valid, bp_l1i_valid, bp_l0_cacheline,
           bp_branch_data, l1i_valid, l1i_cacheline, flush_in, decode_ready,
    output fetch_ready, decode_valid, decode_pc, decode_lane_valid, decode_instr,
           decode_branch_data
  );

endinterface

`default_nettype wire

// File: rtl/fetch_unit_queue.sv
//------------------------------------------------------------------------------
// Module   : fetch_queue
// Brief    : FIFO of fetch bundles with push/pop/flush; push is honoured when
//            full only if a pop happens in the same cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                   clk_in,
  input  wire logic                   rst_N_in,
  input  wire logic                   i_push,
  input  wire fetch_bundle_t          i_push_data,
  input  wire logic                   i_pop,
  input  wire logic                   i_flush,
  output fetch_bundle_t               o_head,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic                        o_full,
  output logic                        o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_bundle_t    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy tracking; flush empties the queue in one cycle
  always_ff @(posedge clk_in) begin
    if (!rst_N_in || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  // Payload storage; contents are only meaningful between rd and wr
  always_ff @(posedge clk_in) begin
    if (w_do_push && !i_flush) r_mem[r_wr] <= i_push_data;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit
// Brief    : Extracts up to SUPER_SCALAR_WIDTH instructions per predicted PC
//            from an L0 or L1I line, truncates at line end / first redirect,
//            and queues bundles for decode. Handles flush and stale L1I drop.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int CACHE_LINE_WIDTH   = 64,
  parameter int INSTRUCTION_WIDTH  = fetch_unit_pkg::INSTRUCTION_WIDTH,
  parameter int SUPER_SCALAR_WIDTH = fetch_unit_pkg::SUPER_SCALAR_WIDTH,
  parameter int QUEUE_DEPTH        = 4
) (
  input  wire logic    clk_in,
  input  wire logic    rst_N_in,
  fetch_unit_if.slave  bus
);

  localparam int OFF_W = $clog2(CACHE_LINE_WIDTH);

  logic [1:0]                           r_state;
  logic [1:0]                           w_state_nxt;
  logic [63:0]                          r_pc;
  uop_branch [SUPER_SCALAR_WIDTH-1:0]   r_br;
  logic                                 w_accept;
  logic                                 w_push;
  logic                                 w_latch;
  logic                                 w_pop;
  fetch_bundle_t                        w_push_data;
  fetch_bundle_t                        w_head;
  logic [$clog2(QUEUE_DEPTH):0]         w_count;
  logic                                 w_full;
  logic                                 w_empty;

  // Lanes past the line end or past the first redirecting lane are dropped;
  // the redirecting lane itself stays in the bundle.
  function automatic fetch_bundle_t build_bundle(
    input logic [63:0]                        pc,
    input logic [CACHE_LINE_WIDTH*8-1:0]      line,
    input uop_branch [SUPER_SCALAR_WIDTH-1:0] br
  );
    fetch_bundle_t                 b;
    logic                          stop;
    int                            idx;
    logic [CACHE_LINE_WIDTH*8-1:0] sh;
    b             = '0;
    b.pc          = pc;
    b.branch_data = br;
    stop          = 1'b0;
    for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
      idx = int'(pc[OFF_W-1:0]) + INSTRUCTION_WIDTH * i;
      if (!stop && (idx <= CACHE_LINE_WIDTH - INSTRUCTION_WIDTH)) begin
        sh              = line >> (idx * 8);
        b.lane_valid[i] = 1'b1;
        b.instr[i]      = sh[31:0];
        if (is_redirect(sh[31:0], br[i].predict_taken)) stop = 1'b1;
      end
    end
    return b;
  endfunction

  assign bus.fetch_ready = (r_state == ST_RUN) && !w_full;
  assign w_accept        = bus.bp_pc_valid && bus.fetch_ready && !bus.flush_in;
  assign w_pop           = !w_empty && bus.decode_ready;

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) r_state <= ST_RUN;
    else           r_state <= w_state_nxt;
  end

  // FSM next-state logic; flush takes priority over every other event
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_accept && !bus.bp_l0_valid && bus.bp_l1i_valid) w_state_nxt = ST_WAIT_L1I;
      end
      ST_WAIT_L1I: begin
        if (bus.flush_in)       w_state_nxt = bus.l1i_valid ? ST_RUN : ST_DROP;
        else if (bus.l1i_valid) w_state_nxt = ST_RUN;
      end
      ST_DROP: begin
        if (!bus.flush_in && bus.l1i_valid) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs: enqueue control, bundle source select, L1I request latch
  always_comb begin
    w_push      = 1'b0;
    w_latch     = 1'b0;
    w_push_data = build_bundle(bus.bp_pred_pc, bus.bp_l0_cacheline, bus.bp_branch_data);
    case (r_state)
      ST_RUN: begin
        w_push  = w_accept && bus.bp_l0_valid;
        w_latch = w_accept && !bus.bp_l0_valid && bus.bp_l1i_valid;
      end
      ST_WAIT_L1I: begin
        w_push      = bus.l1i_valid && !bus.flush_in;
        w_push_data = build_bundle(r_pc, bus.l1i_cacheline, r_br);
      end
      default: ;
    endcase
  end

  // PC and predictions held while the L1I line is outstanding
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      r_pc <= '0;
      r_br <= '0;
    end else if (w_latch) begin
      r_pc <= bus.bp_pred_pc;
      r_br <= bus.bp_branch_data;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk_in      (clk_in),
    .rst_N_in    (rst_N_in),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (bus.flush_in),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Decode outputs read zero whenever the queue holds nothing
  assign bus.decode_valid       = !w_empty;
  assign bus.decode_pc          = w_empty ? '0 : w_head.pc;
  assign bus.decode_lane_valid  = w_empty ? '0 : w_head.lane_valid;
  assign bus.decode_instr       = w_empty ? '0 : w_head.instr;
  assign bus.decode_branch_data = w_empty ? '0 : w_head.branch_data;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk_in;
  logic rst_N_in;
  int   checks;
  int   errors;

  fetch_unit_if bus ();

  fetch_unit #(
    .CACHE_LINE_WIDTH   (64),
    .INSTRUCTION_WIDTH  (4),
    .SUPER_SCALAR_WIDTH (2),
    .QUEUE_DEPTH        (4)
  ) dut (
    .clk_in   (clk_in),
    .rst_N_in (rst_N_in),
    .bus      (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // BP must never present a PC that the fetch unit cannot take
  always @(negedge clk_in) begin
    if (rst_N_in && bus.bp_pc_valid && !bus.fetch_ready && !bus.flush_in) begin
      errors++;
      $error("FAIL bp_protocol observed=pc_valid_while_not_ready expected=idle");
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [511:0] mkline(input logic [31:0] base);
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = base + 32'(w);
    return l;
  endfunction

  task automatic issue(input logic [63:0] pc, input logic l0, input logic l1i,
                       input logic [511:0] line);
    bus.bp_pc_valid     = 1'b1;
    bus.bp_pred_pc      = pc;
    bus.bp_l0_valid     = l0;
    bus.bp_l1i_valid    = l1i;
    bus.bp_l0_cacheline = line;
  endtask

  task automatic idle_bp();
    bus.bp_pc_valid    = 1'b0;
    bus.bp_l0_valid    = 1'b0;
    bus.bp_l1i_valid   = 1'b0;
    bus.bp_branch_data = '0;
  endtask

  logic [511:0] line_n;
  logic [511:0] line_i;
  logic [511:0] line_t;

  initial begin
    checks = 0;
    errors = 0;
    line_n = mkline(32'hD503_0000);
    line_i = mkline(32'hA000_0000);
    rst_N_in            = 1'b0;
    bus.bp_pred_pc      = '0;
    bus.bp_l0_cacheline = '0;
    bus.l1i_valid       = 1'b0;
    bus.l1i_cacheline   = '0;
    bus.flush_in        = 1'b0;
    bus.decode_ready    = 1'b1;
    idle_bp();
    step();
    step();
    rst_N_in = 1'b1;

    // Reset state
    chk("rst_valid", 64'(bus.decode_valid), 64'd0);
    chk("rst_mask",  64'(bus.decode_lane_valid), 64'd0);
    chk("rst_pc",    bus.decode_pc, 64'd0);
    chk("rst_instr", 64'(bus.decode_instr), 64'd0);
    chk("rst_br",    64'(bus.decode_branch_data[0].predict_target), 64'd0);
    chk("rst_ready", 64'(bus.fetch_ready), 64'd1);

    // L0 hit, full bundle
    issue(64'h1000, 1'b1, 1'b0, line_n);
    chk("l0_same_cycle_valid", 64'(bus.decode_valid), 64'd0);
    step();
    idle_bp();
    chk("l0_valid", 64'(bus.decode_valid), 64'd1);
    chk("l0_pc",    bus.decode_pc, 64'h1000);
    chk("l0_mask",  64'(bus.decode_lane_valid), 64'd3);
    chk("l0_instr", 64'(bus.decode_instr), 64'hD5030001_D5030000);
    step();
    chk("l0_popped", 64'(bus.decode_valid), 64'd0);

    // Line-end truncation
    issue(64'h103C, 1'b1, 1'b0, line_n);
    step();
    idle_bp();
    chk("end_mask",  64'(bus.decode_lane_valid), 64'd1);
    chk("end_instr", 64'(bus.decode_instr[0]), 64'hD503000F);
    step();

    // Unconditional branch in lane 0
    line_t = line_n;
    line_t[31:0] = 32'h1400_0000;
    issue(64'h2000, 1'b1, 1'b0, line_t);
    step();
    idle_bp();
    chk("b_mask",  64'(bus.decode_lane_valid), 64'd1);
    chk("b_instr", 64'(bus.decode_instr[0]), 64'h14000000);
    step();

    // bcond not predicted taken
    line_t = line_n;
    line_t[31:0] = 32'h5400_0000;
    issue(64'h2000, 1'b1, 1'b0, line_t);
    step();
    idle_bp();
    chk("bcond_nt_mask", 64'(bus.decode_lane_valid), 64'd3);
    step();

    // bcond predicted taken, branch data passes through
    issue(64'h2000, 1'b1, 1'b0, line_t);
    bus.bp_branch_data[0].predict_taken  = 1'b1;
    bus.bp_branch_data[0].predict_target = 64'h2400;
    step();
    idle_bp();
    chk("bcond_t_mask",   64'(bus.decode_lane_valid), 64'd1);
    chk("bcond_t_taken",  64'(bus.decode_branch_data[0].predict_taken), 64'd1);
    chk("bcond_t_target", bus.decode_branch_data[0].predict_target, 64'h2400);
    step();

    // RET in the last lane is kept
    line_t = line_n;
    line_t[63:32] = 32'hD65F_03C0;
    issue(64'h2000, 1'b1, 1'b0, line_t);
    step();
    idle_bp();
    chk("ret_lane1_mask", 64'(bus.decode_lane_valid), 64'd3);
    step();

    // BL seen through a non-zero offset
    line_t = line_n;
    line_t[63:32] = 32'h9400_0000;
    issue(64'h2004, 1'b1, 1'b0, line_t);
    step();
    idle_bp();
    chk("bl_off4_mask",  64'(bus.decode_lane_valid), 64'd1);
    chk("bl_off4_instr", 64'(bus.decode_instr[0]), 64'h94000000);
    step();

    // L1I path
    issue(64'h3000, 1'b0, 1'b1, line_n);
    bus.bp_branch_data[1].predict_target = 64'h3333;
    step();
    idle_bp();
    for (int i = 0; i < 5; i++) begin
      chk("l1i_wait_ready", 64'(bus.fetch_ready), 64'd0);
      chk("l1i_wait_valid", 64'(bus.decode_valid), 64'd0);
      if (i < 4) step();
    end
    bus.l1i_valid     = 1'b1;
    bus.l1i_cacheline = line_i;
    step();
    bus.l1i_valid = 1'b0;
    chk("l1i_valid",  64'(bus.decode_valid), 64'd1);
    chk("l1i_pc",     bus.decode_pc, 64'h3000);
    chk("l1i_mask",   64'(bus.decode_lane_valid), 64'd3);
    chk("l1i_instr",  64'(bus.decode_instr), 64'hA0000001_A0000000);
    chk("l1i_br",     bus.decode_branch_data[1].predict_target, 64'h3333);
    chk("l1i_ready",  64'(bus.fetch_ready), 64'd1);
    step();

    // Flush during WAIT_L1I with a queued bundle present
    bus.decode_ready = 1'b0;
    issue(64'h5000, 1'b1, 1'b0, line_n);
    step();
    issue(64'h3100, 1'b0, 1'b1, line_n);
    step();
    idle_bp();
    chk("fl_pre_valid", 64'(bus.decode_valid), 64'd1);
    chk("fl_pre_pc",    bus.decode_pc, 64'h5000);
    bus.flush_in = 1'b1;
    step();
    bus.flush_in = 1'b0;
    chk("fl_cleared", 64'(bus.decode_valid), 64'd0);
    chk("fl_drop_ready", 64'(bus.fetch_ready), 64'd0);
    step();
    bus.l1i_valid     = 1'b1;
    bus.l1i_cacheline = line_i;
    chk("fl_drop_ready2", 64'(bus.fetch_ready), 64'd0);
    step();
    bus.l1i_valid = 1'b0;
    chk("fl_stale_dropped", 64'(bus.decode_valid), 64'd0);
    chk("fl_ready_back",    64'(bus.fetch_ready), 64'd1);
    bus.decode_ready = 1'b1;
    issue(64'h4000, 1'b1, 1'b0, line_n);
    step();
    idle_bp();
    chk("fl_new_valid", 64'(bus.decode_valid), 64'd1);
    chk("fl_new_pc",    bus.decode_pc, 64'h4000);
    chk("fl_new_instr", 64'(bus.decode_instr), 64'hD5030001_D5030000);
    step();

    // Backpressure: fill, then drain in order
    bus.decode_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_fill_ready", 64'(bus.fetch_ready), 64'd1);
      issue(64'h6000 + 64'(8 * i), 1'b1, 1'b0, line_n);
      step();
    end
    idle_bp();
    chk("bp_full_ready", 64'(bus.fetch_ready), 64'd0);
    chk("bp_full_valid", 64'(bus.decode_valid), 64'd1);
    bus.decode_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) chk("bp_drain_ready", 64'(bus.fetch_ready), 64'd1);
      chk("bp_drain_valid", 64'(bus.decode_valid), 64'd1);
      chk("bp_drain_pc",    bus.decode_pc, 64'h6000 + 64'(8 * i));
      chk("bp_drain_instr", 64'(bus.decode_instr),
          {32'hD503_0000 + 32'(2 * i + 1), 32'hD503_0000 + 32'(2 * i)});
      step();
    end
    chk("bp_empty_valid", 64'(bus.decode_valid), 64'd0);
    chk("bp_empty_ready", 64'(bus.fetch_ready), 64'd1);

    // Reset while an L1I request is outstanding
    issue(64'h7000, 1'b0, 1'b1, line_n);
    step();
    idle_bp();
    chk("mr_wait_ready", 64'(bus.fetch_ready), 64'd0);
    rst_N_in = 1'b0;
    step();
    rst_N_in = 1'b1;
    chk("mr_ready", 64'(bus.fetch_ready), 64'd1);
    bus.l1i_valid     = 1'b1;
    bus.l1i_cacheline = line_i;
    step();
    bus.l1i_valid = 1'b0;
    chk("mr_no_enqueue", 64'(bus.decode_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage directly downstream of the branch predictor.
- Takes each predicted fetch PC plus its line source (L0 line supplied with the PC, or L1I response pending) and extracts up to SUPER_SCALAR_WIDTH instructions from the 64-byte line.
- Truncates the bundle at the line end and at the first predicted-redirecting branch, then buffers bundles in a small queue feeding decode over a valid/ready handshake.
- Handles misprediction flush, including discarding a stale in-flight L1I response.

Parameters:
- CACHE_LINE_WIDTH, 64, line size in bytes.
- INSTRUCTION_WIDTH, op_pkg::INSTRUCTION_WIDTH, instruction size in bytes (4).
- SUPER_SCALAR_WIDTH, op_pkg::SUPER_SCALAR_WIDTH, lanes per bundle.
- QUEUE_DEPTH, 4, bundle queue entries (power of two, >=2).

Ports:
- clk_in  in  1  clock
- rst_N_in  in  1  reset; synchronous, active-low
- bp_pc_valid  in  1  BP presents a new fetch PC this cycle
- bp_pred_pc  in  64  fetch PC
- bp_l0_valid  in  1  bp_l0_cacheline holds the line for bp_pred_pc
- bp_l1i_valid  in  1  line must come from L1I
- bp_l0_cacheline  in  CACHE_LINE_WIDTH*8  L0 line
- bp_branch_data  in  uop_branch[SSW]  per-lane branch predictions
- l1i_valid  in  1  L1I response valid
- l1i_cacheline  in  CACHE_LINE_WIDTH*8  L1I line
- flush_in  in  1  misprediction redirect (x_pc_incorrect)
- fetch_ready  out  1  can accept a BP PC this cycle
- decode_ready  in  1  decode accepts the head bundle
- decode_valid  out  1  head bundle valid
- decode_pc  out  64  PC of lane 0
- decode_lane_valid  out  SSW  per-lane valid mask, contiguous from lane 0
- decode_instr  out  SSW x 32  instruction bits per lane
- decode_branch_data  out  uop_branch[SSW]  passed through from BP

Behaviour:
- Reset (rst_N_in low at a posedge): state=RUN, queue empty; decode_valid=0, decode_lane_valid=0, decode_pc=0, decode_instr=0, decode_branch_data=0. fetch_ready=1 in the first cycle after reset. Reset mid-operation discards everything, including any in-flight L1I line.
- States: RUN, WAIT_L1I, DROP.
- fetch_ready is combinational: state==RUN && count<QUEUE_DEPTH. It does not depend on decode_ready. A BP PC is accepted iff bp_pc_valid && fetch_ready && !flush_in.
- RUN, accepted with bp_l0_valid=1: build a bundle from bp_l0_cacheline and enqueue at this edge; visible at the queue head no earlier than the next cycle.
- RUN, accepted with bp_l1i_valid=1: latch pc and branch data, go to WAIT_L1I. If both source flags are set, L0 wins.
- WAIT_L1I: on l1i_valid, build a bundle from l1i_cacheline using the latched pc/branch data, enqueue, return to RUN.
- Bundle build, with off = pc[5:0]:
  - Lane i is a candidate iff off + 4i <= CACHE_LINE_WIDTH - INSTRUCTION_WIDTH.
  - Instruction bits are little-endian bytes at off+4i.
  - Lane k terminates the bundle if it is a candidate and is B (bits[31:26]=000101), BL (100101), RET (bits[31:21]=11010110010), or bcond (bits[31:24]=01010100) with bp_branch_data[k].predict_taken=1.
  - Lanes after the first terminating lane are invalid. The mask is always contiguous and non-empty (off is word-aligned by contract).
- Queue: FIFO of QUEUE_DEPTH bundles. Pop when decode_valid && decode_ready. Push and pop in the same cycle are allowed when full (count unchanged). decode_* are driven from the head entry; decode_valid = count>0.
- Flush (flush_in=1), highest priority:
  - Queue cleared at this edge; decode_valid=0 next cycle.
  - No enqueue this cycle.
  - RUN stays RUN.
  - WAIT_L1I with l1i_valid this cycle: response discarded, go to RUN.
  - WAIT_L1I without l1i_valid: go to DROP.
  - DROP stays DROP.
- DROP: fetch_ready=0. The next l1i_valid is discarded, then go to RUN.
- bp_pc_valid while fetch_ready=0 is ignored; the bench asserts BP never does this without flush.
- PC arithmetic is 64-bit wraparound; no exceptions are raised.

Decomposition:
- uop_pkg: fetch_bundle_t (pc, lane_valid, instr[SSW], branch_data[SSW]).
- op_pkg: opcode match constants (OPC_B, OPC_BL, OPC_RET, OPC_BCOND).
- Sub-module fetch_queue: parameterised FIFO of fetch_bundle_t with push, pop, flush, count, full, empty.
- Bundle extraction is a function inside fetch_unit.

Test Plan:
- L0 hit: pc=0x1000, bp_l0_valid, line holds NOPs, SSW=2 -> bundle next cycle with pc=0x1000, mask=11, instr = words at bytes 0 and 4.
- Line-end truncation: pc=0x103C via L0 -> mask=01, instr = bytes 60..63.
- Branch truncation: pc=0x2000, lane0 = B, lane1 = NOP -> mask=01. With lane0 = bcond and predict_taken=0 -> mask=11. With predict_taken=1 -> mask=01.
- L1I path: bp_l1i_valid at pc=0x3000, l1i_valid after 5 cycles -> fetch_ready=0 during the wait; bundle appears the cycle after l1i_valid; back in RUN.
- Flush during WAIT_L1I: flush_in two cycles before l1i_valid -> queue empty, stale line never enqueued, fetch_ready=1 the cycle after l1i_valid. Then a new L0 PC 0x4000 is enqueued normally.
- Backpressure: decode_ready=0, 4 L0 PCs -> fetch_ready=0 once count=4. decode_ready=1 -> bundles drain in order, fetch_ready returns to 1.
